// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: shared frame counter, clamped and
// slew-limited per-channel pulse widths, frame-synchronous output enable.
module servo_pwm_multi #(
    parameter int CH         = 2,
    parameter int W          = 20,
    parameter int PERIOD_CNT = 1000000,
    parameter int MIN_PW     = 24500,
    parameter int MAX_PW     = 37000,
    parameter int DEFAULT_PW = 30500,
    parameter int STEP       = 500
) (
    input  logic                                   osc,
    input  logic                                   reset_n,
    input  logic                                   enable,
    input  logic                                   wr_en,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] wr_ch,
    input  logic [W-1:0]                           wr_pw,
    output logic [CH-1:0]                          pwm_out,
    output logic                                   frame_tick,
    output logic [CH-1:0]                          at_target
);

    localparam logic [W-1:0] LAST   = W'(PERIOD_CNT - 1);
    localparam logic [W-1:0] MIN_V  = W'(MIN_PW);
    localparam logic [W-1:0] MAX_V  = W'(MAX_PW);
    localparam logic [W-1:0] DEF_V  = W'(DEFAULT_PW);
    localparam logic [W-1:0] STEP_W = W'(STEP);
    localparam logic [W:0]   STEP_X = (W + 1)'(STEP);

    logic [W-1:0] cnt;
    logic         en_frame;
    logic         boundary;
    logic         wr_hit;
    logic [W-1:0] wr_pw_clamped;
    logic [W-1:0] tgt     [CH];
    logic [W-1:0] cur     [CH];
    logic [W-1:0] cur_nxt [CH];
    logic [W:0]   diff    [CH];
    logic         up      [CH];

    assign boundary   = (cnt == LAST);
    assign frame_tick = boundary;

    always_comb begin
        wr_hit = wr_en && (32'(wr_ch) < CH);
        if (wr_pw < MIN_V)
            wr_pw_clamped = MIN_V;
        else if (wr_pw > MAX_V)
            wr_pw_clamped = MAX_V;
        else
            wr_pw_clamped = wr_pw;
    end

    // Difference is taken one bit wider so the magnitude never wraps.
    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            up[i]   = (tgt[i] > cur[i]);
            diff[i] = up[i] ? ({1'b0, tgt[i]} - {1'b0, cur[i]})
                            : ({1'b0, cur[i]} - {1'b0, tgt[i]});
            if ((STEP == 0) || (diff[i] <= STEP_X))
                cur_nxt[i] = tgt[i];
            else if (up[i])
                cur_nxt[i] = cur[i] + STEP_W;
            else
                cur_nxt[i] = cur[i] - STEP_W;
        end
    end

    always_comb begin
        at_target = '0;
        for (int unsigned i = 0; i < CH; i++)
            at_target[i] = (cur[i] == tgt[i]);
    end

    always_ff @(posedge osc or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            en_frame <= 1'b0;
            pwm_out  <= '0;
            for (int unsigned i = 0; i < CH; i++) begin
                tgt[i] <= DEF_V;
                cur[i] <= DEF_V;
            end
        end else begin
            if (boundary) begin
                cnt      <= '0;
                en_frame <= enable;
            end else begin
                cnt <= cnt + 1'b1;
            end
            for (int unsigned i = 0; i < CH; i++) begin
                pwm_out[i] <= en_frame && (cnt < cur[i]);
                if (boundary && en_frame)
                    cur[i] <= cur_nxt[i];
            end
            // Slew above reads tgt before this cycle's write lands.
            if (wr_hit)
                tgt[wr_ch] <= wr_pw_clamped;
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Randomised self-checking bench for servo_pwm_multi against a frame-level model.
module tb_servo_pwm_multi;

    localparam int W    = 20;
    localparam int P    = 100;
    localparam int MINW = 10;
    localparam int MAXW = 40;
    localparam int DEFW = 20;
    localparam int STP  = 5;

    logic         osc = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         wr_en;
    logic         wr_ch;
    logic [W-1:0] wr_pw;
    logic [1:0]   pwm_out;
    logic         frame_tick;
    logic [1:0]   at_target;

    logic         wr_en3;
    logic [1:0]   wr_ch3;
    logic [W-1:0] wr_pw3;
    logic [2:0]   pwm_out3;
    logic         frame_tick3;
    logic [2:0]   at_target3;

    int n_checks = 0;
    int n_err    = 0;

    servo_pwm_multi #(.CH(2), .W(W), .PERIOD_CNT(P), .MIN_PW(MINW), .MAX_PW(MAXW),
                      .DEFAULT_PW(DEFW), .STEP(STP)) dut (
        .osc(osc), .reset_n(reset_n), .enable(enable), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_pw(wr_pw), .pwm_out(pwm_out), .frame_tick(frame_tick), .at_target(at_target)
    );

    servo_pwm_multi #(.CH(3), .W(W), .PERIOD_CNT(P), .MIN_PW(MINW), .MAX_PW(MAXW),
                      .DEFAULT_PW(DEFW), .STEP(STP)) dut3 (
        .osc(osc), .reset_n(reset_n), .enable(enable), .wr_en(wr_en3), .wr_ch(wr_ch3),
        .wr_pw(wr_pw3), .pwm_out(pwm_out3), .frame_tick(frame_tick3), .at_target(at_target3)
    );

    always #5 osc = ~osc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v < MINW) return MINW;
        if (v > MAXW) return MAXW;
        return v;
    endfunction

    function automatic int slew(input int c, input int t);
        if (STP == 0) return t;
        if (t - c > STP) return c + STP;
        if (c - t > STP) return c - STP;
        return t;
    endfunction

    // Reference model: frame position, targets, applied widths, frame enable.
    int   m_cnt;
    logic m_en;
    logic m_wrap;
    logic [1:0] m_pwm;
    int   m_tgt [2];
    int   m_cur [2];
    int   exp_w [2];
    int   exp_last [2];
    int   meas [2];
    int   hist [2][$];

    always @(posedge osc or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt  <= 0;
            m_en   <= 1'b0;
            m_wrap <= 1'b0;
            m_pwm  <= '0;
            for (int i = 0; i < 2; i++) begin
                m_tgt[i]    <= DEFW;
                m_cur[i]    <= DEFW;
                exp_w[i]    <= 0;
                exp_last[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++)
                m_pwm[i] <= m_en && (m_cnt < m_cur[i]);
            m_wrap <= (m_cnt == P - 1);
            if (m_cnt == P - 1) begin
                m_cnt <= 0;
                m_en  <= enable;
                for (int i = 0; i < 2; i++) begin
                    m_cur[i]    <= m_en ? slew(m_cur[i], m_tgt[i]) : m_cur[i];
                    exp_w[i]    <= enable ? (m_en ? slew(m_cur[i], m_tgt[i]) : m_cur[i]) : 0;
                    exp_last[i] <= exp_w[i];
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
            if (wr_en)
                m_tgt[int'(wr_ch)] <= clamp(int'(wr_pw));
        end
    end

    always @(negedge osc) begin
        if (!reset_n) begin
            meas[0] <= 0;
            meas[1] <= 0;
        end else begin
            check_val("pwm", 32'(pwm_out), 32'(m_pwm));
            check_val("frame_tick", 32'(frame_tick), 32'(m_cnt == P - 1));
            check_val("at_target", 32'(at_target),
                      {30'b0, m_cur[1] == m_tgt[1], m_cur[0] == m_tgt[0]});
            for (int i = 0; i < 2; i++) begin
                if (m_wrap) begin
                    check_val("width", 32'(meas[i] + int'(pwm_out[i])), 32'(exp_last[i]));
                    if (meas[i] != 0)
                        check_val("width_range",
                                  32'(meas[i] >= MINW && meas[i] <= MAXW), 32'd1);
                    hist[i].push_back(meas[i] + int'(pwm_out[i]));
                    meas[i] <= 0;
                end else begin
                    meas[i] <= meas[i] + int'(pwm_out[i]);
                end
            end
        end
    end

    task automatic wait_cnt(input int k);
        for (int c = 0; c < 2 * P; c++) begin
            @(negedge osc);
            if (m_cnt == k) return;
        end
        check_val("wait_cnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_hist(input int n);
        for (int c = 0; c < 12 * P; c++) begin
            @(negedge osc);
            if (hist[0].size() >= n) return;
        end
        check_val("wait_frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_write(input int ch, input int pw);
        wr_en = 1'b1;
        wr_ch = 1'(ch);
        wr_pw = W'(pw);
        @(negedge osc);
        wr_en = 1'b0;
    endtask

    int n;

    initial begin
        reset_n = 1'b0; enable = 1'b0;
        wr_en = 1'b0; wr_ch = 1'b0; wr_pw = '0;
        wr_en3 = 1'b0; wr_ch3 = '0; wr_pw3 = '0;
        repeat (3) @(negedge osc);
        check_val("rst_pwm", 32'(pwm_out), 32'd0);
        check_val("rst_tick", 32'(frame_tick), 32'd0);
        check_val("rst_at_target", 32'(at_target), 32'd3);
        check_val("rst_at_target3", 32'(at_target3), 32'd7);
        enable = 1'b1;
        reset_n = 1'b1;

        wait_hist(3);
        check_val("frame0_low0", 32'(hist[0][0]), 32'd0);
        check_val("frame0_low1", 32'(hist[1][0]), 32'd0);
        check_val("frame1_w0", 32'(hist[0][1]), 32'd20);
        check_val("frame1_w1", 32'(hist[1][1]), 32'd20);

        wait_cnt(50);
        n = hist[0].size();
        do_write(0, 35);
        check_val("at_target0_pending", 32'(at_target[0]), 32'd0);
        wait_hist(n + 2);
        check_val("at_target0_before3", 32'(at_target[0]), 32'd0);
        wait_hist(n + 3);
        check_val("at_target0_after3", 32'(at_target[0]), 32'd1);
        wait_hist(n + 4);
        check_val("slew_w20", 32'(hist[0][n]), 32'd20);
        check_val("slew_w25", 32'(hist[0][n + 1]), 32'd25);
        check_val("slew_w30", 32'(hist[0][n + 2]), 32'd30);
        check_val("slew_w35", 32'(hist[0][n + 3]), 32'd35);
        check_val("ch1_steady", 32'(hist[1][n + 3]), 32'd20);

        n = hist[0].size();
        do_write(1, 5);
        wait_hist(n + 4);
        check_val("clamp_lo", 32'(hist[1][n + 3]), 32'd10);
        wr_en = 1'b1; wr_ch = 1'b1; wr_pw = W'(12);
        @(negedge osc);
        wr_pw = W'(90);
        @(negedge osc);
        wr_en = 1'b0;
        n = hist[0].size();
        wait_hist(n + 8);
        check_val("clamp_hi", 32'(hist[1][n + 7]), 32'd40);

        for (int k = 0; k < 6; k++) begin
            wait_cnt(int'($urandom_range(P - 2, 0)));
            do_write(int'($urandom_range(1, 0)), int'($urandom_range(60, 0)));
            if ($urandom_range(1, 0) == 1) do_write(1, int'($urandom_range(50, 5)));
        end
        do_write(1, 40);
        do_write(0, 20);
        n = hist[0].size();
        wait_hist(n + 8);

        wait_cnt(P - 1);
        n = hist[0].size();
        do_write(0, 25);
        wait_hist(n + 3);
        check_val("bwrite_cur", 32'(hist[0][n]), 32'd20);
        check_val("bwrite_next", 32'(hist[0][n + 1]), 32'd20);
        check_val("bwrite_after", 32'(hist[0][n + 2]), 32'd25);

        wait_cnt(10);
        n = hist[0].size();
        do_write(0, 40);
        wait_cnt(50);
        enable = 1'b0;
        wait_hist(n + 2);
        check_val("paused_at_target0", 32'(at_target[0]), 32'd0);
        enable = 1'b1;
        wait_hist(n + 5);
        check_val("en_last_frame", 32'(hist[0][n]), 32'd25);
        check_val("en_off_frame1", 32'(hist[0][n + 1]), 32'd0);
        check_val("en_off_frame2", 32'(hist[0][n + 2]), 32'd0);
        check_val("en_resume30", 32'(hist[0][n + 3]), 32'd30);
        check_val("en_resume35", 32'(hist[0][n + 4]), 32'd35);

        wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_pw3 = W'(40);
        @(negedge osc);
        wr_en3 = 1'b0;
        @(negedge osc);
        check_val("ignore_ch3", 32'(at_target3), 32'd7);
        wr_en3 = 1'b1; wr_ch3 = 2'd2; wr_pw3 = W'(40);
        @(negedge osc);
        wr_en3 = 1'b0;
        check_val("write_ch2", 32'(at_target3), 32'd3);

        wait_cnt(12);
        check_val("pre_reset_pwm", 32'(pwm_out), 32'd3);
        #3 reset_n = 1'b0;
        #1;
        check_val("reset_async_pwm", 32'(pwm_out), 32'd0);
        check_val("reset_async_at", 32'(at_target), 32'd3);
        @(negedge osc);
        #2 reset_n = 1'b1;
        n = hist[0].size();
        wait_hist(n + 2);
        check_val("post_reset_low", 32'(hist[0][n]), 32'd0);
        check_val("post_reset_w0", 32'(hist[0][n + 1]), 32'd20);
        check_val("post_reset_w1", 32'(hist[1][n + 1]), 32'd20);
        check_val("post_reset_at3", 32'(at_target3), 32'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/servo_pwm_multi.md
# servo_pwm_multi

Multi-channel hobby-servo PWM generator. It produces CH independent pulse trains that share one frame counter, and each channel's pulse width is set through a simple write port. Widths are clamped to a safe range and slew-limited, so the steering servo never jumps on a new command. The block sits between the steering/obstacle decision logic and the servo output pins, and replaces single-channel fixed-width servo drivers.

## Interface
- `CH`, 2: number of servo channels (1..8).
- `W`, 20: width of the frame counter and of the pulse-width fields, in bits.
- `PERIOD_CNT`, 1000000: frame length in `osc` cycles (20 ms at 50 MHz); must satisfy PERIOD_CNT <= 2^W.
- `MIN_PW`, 24500: minimum pulse width, in cycles.
- `MAX_PW`, 37000: maximum pulse width, in cycles; must satisfy MIN_PW <= MAX_PW < PERIOD_CNT.
- `DEFAULT_PW`, 30500: reset and centre width; must satisfy MIN_PW <= DEFAULT_PW <= MAX_PW.
- `STEP`, 500: maximum change of the applied width per frame; 0 means the target is applied in one frame.
- `osc`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `enable`  in  1  output enable; sampled once per frame.
- `wr_en`  in  1  one-cycle write strobe for a target width.
- `wr_ch`  in  max(1,$clog2(CH))  channel index for the write.
- `wr_pw`  in  W  requested pulse width, in cycles.
- `pwm_out`  out  CH  servo PWM outputs, registered.
- `frame_tick`  out  1  one-cycle pulse on the last cycle of each frame.
- `at_target`  out  CH  per channel: 1 when the applied width equals the target width.

## Operation
- Frame counter `cnt` counts 0..PERIOD_CNT-1 and then wraps to 0. The frame boundary is the cycle with `cnt == PERIOD_CNT-1`.
- Each channel holds two registers:
  - `tgt[i]`: the target width.
  - `cur[i]`: the width currently applied to the output.
- Write path:
  - A write with `wr_en=1` and `wr_ch < CH` loads `tgt[wr_ch]` with `wr_pw` clamped to the range [MIN_PW, MAX_PW].
  - A write with `wr_ch >= CH` is ignored. No error flag is raised.
  - A write takes effect in `tgt` on the next clock edge. There is no backpressure; every cycle accepts a write.
- Slew update happens on the frame-boundary edge, for each channel:
  - If `cur == tgt`: no change.
  - If `|tgt-cur| <= STEP` or `STEP == 0`: `cur <= tgt`.
  - Otherwise `cur` moves toward `tgt` by exactly STEP.
  - The slew uses the value `tgt` holds at the start of the boundary cycle. A write issued in the boundary cycle is used at the next boundary.
- Enable:
  - `en_frame` is loaded from `enable` on the boundary edge.
  - While `en_frame == 0`, all outputs stay low and `cur` is frozen (no slew). `tgt` still accepts writes.
  - Toggling `enable` mid-frame has no effect until the next boundary.
- Output: `pwm_out[i]` is registered as `en_frame && (cnt < cur[i])`. Each pulse is exactly `cur[i]` cycles long and lags `cnt` by one cycle.
- `at_target[i]` is `(cur[i] == tgt[i])`. It is combinational from the registers.
- Arithmetic:
  - The slew difference is computed at W+1 bits, so there is no wrap.
  - Clamping compares at W bits, unsigned.
  - `cur` never leaves the range [MIN_PW, MAX_PW].

## Timing
- Reset values, applied asynchronously while `reset_n=0`:
  - `cnt = 0`
  - `tgt[i] = cur[i] = DEFAULT_PW`
  - `en_frame = 0`
  - `pwm_out = 0`
  - `frame_tick = 0`
  - `at_target` = all ones
- After reset release the first frame is always low, because `en_frame` is 0. Pulses start in the frame after the first boundary at which `enable=1` is sampled.
- `frame_tick` is high for exactly one cycle: the cycle in which `cnt == PERIOD_CNT-1`.
- Write-to-output latency: a write lands in `tgt` after 1 cycle. `cur` changes at the next boundary. The new width appears on `pwm_out` in the frame that follows.
- Rising edges of `pwm_out` on all channels are simultaneous, one cycle after `cnt` becomes 0.
- Reset asserted mid-pulse: `pwm_out` drops to 0 immediately, with no partial-frame completion.
- Two writes to the same channel in consecutive cycles: the last write wins.

## Test plan
Bench parameters: CH=2, PERIOD_CNT=100, MIN_PW=10, MAX_PW=40, DEFAULT_PW=20, STEP=5.
- Reset then hold `enable=1` -> frame 0 is all low, `frame_tick` pulses every 100 cycles, and both channels then give 20-cycle pulses with simultaneous rising edges.
- Write ch0=35 -> `cur0` goes 25, 30, 35 over three boundaries, pulses measure 25/30/35 cycles, and `at_target[0]` rises after the third boundary. ch1 stays at 20.
- Write ch1=5, then ch1=90 -> `tgt1` clamps to 10, then to 40; widths measured at each frame never fall below 10 or exceed 40.
- Write in the boundary cycle (`cnt=99`): ch0=25 while `cur0=20` -> the next frame is still 20 cycles, the frame after is 25.
- Drop `enable` mid-frame -> the current frame completes normally, the following frames are all low, and a pending slew pauses; re-enabling resumes from the frozen `cur`. A write with `wr_ch=3` changes nothing.
- Assert `reset_n=0` while `pwm_out` is high -> outputs go low within the same cycle, and on release the widths are back at 20 with `at_target` = 2'b11.
